// File: rtl/threshold_detector_pkg.sv
// Shared definitions for the threshold detector: FSM state encoding,
// default parameter values (also used by the smoothing-filter bench) and
// a helper that sizes the hold counter.
`timescale 1ns/1ps
package threshold_detector_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_ARM_HI = 2'd1,
    ST_HIGH   = 2'd2,
    ST_ARM_LO = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_TH_HI = 160;
  localparam int DEF_TH_LO = 96;
  localparam int DEF_HOLD  = 4;
  localparam int DEF_CNT_W = 16;

  // Bits needed to hold the values 0..hold; never less than one bit.
  function automatic int cnt_bits(input int hold);
    return (hold < 2) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/threshold_detector_if.sv
// Sample-in / event-out bundle of the threshold detector.
// The detector connects through the slave modport; the sample source and
// event consumer use the master modport.
`timescale 1ns/1ps
interface threshold_detector_if
  import threshold_detector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             level;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [WIDTH-1:0] peak;
  logic             peak_valid;
  logic [CNT_W-1:0] event_count;

  modport master (
    output in_valid, in_data,
    input  level, rise_pulse, fall_pulse, peak, peak_valid, event_count
  );

  modport slave (
    input  in_valid, in_data,
    output level, rise_pulse, fall_pulse, peak, peak_valid, event_count
  );
endinterface

// File: rtl/threshold_detector_hold_counter.sv
// Consecutive-sample counter for the detector FSM. tc_o flags that the
// next enabled increment brings the count up to HOLD, so the FSM can act on
// the HOLD-th qualifying sample in the same cycle it is accepted.
`timescale 1ns/1ps
module threshold_detector_hold_counter
  import threshold_detector_pkg::*;
#(
  parameter int HOLD = DEF_HOLD,
  parameter int CW   = cnt_bits(HOLD)
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
  localparam logic [CW-1:0] LAST_C = CW'(HOLD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over enable; the count saturates at HOLD and never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != HOLD_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST_C);
endmodule

// File: rtl/threshold_detector.sv
// Hysteresis level detector for the smoothed sample stream: dual thresholds
// plus a consecutive-sample hold, producing registered rise/fall pulses, the
// peak of each completed excursion and a running rise count.
// Optional: define THRESH_DETECT_RUNTIME_TH_EN to take thresholds from the
// th_hi/th_lo ports (latched only while the detector sits in LOW).
`timescale 1ns/1ps
module threshold_detector
  import threshold_detector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TH_HI = DEF_TH_HI,
  parameter int TH_LO = DEF_TH_LO,
  parameter int HOLD  = DEF_HOLD,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef THRESH_DETECT_RUNTIME_TH_EN
  input  logic [WIDTH-1:0] th_hi,
  input  logic [WIDTH-1:0] th_lo,
`endif
  threshold_detector_if.slave bus
);
  state_t           state_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             peak_valid_q;
  logic [WIDTH-1:0] peak_q;
  logic [WIDTH-1:0] tracker_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] th_hi_cur;
  logic [WIDTH-1:0] th_lo_cur;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] tracked_max;
  logic             valid;
  logic             hi_ok;
  logic             lo_ok;
  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_tc;

`ifdef THRESH_DETECT_RUNTIME_TH_EN
  logic [WIDTH-1:0] th_hi_q;
  logic [WIDTH-1:0] th_lo_q;

  // Shadow thresholds follow the ports only in LOW so an excursion in
  // progress is always judged against the thresholds it started with.
  always_ff @(posedge CLK) begin
    if (RST) begin
      th_hi_q <= WIDTH'(TH_HI);
      th_lo_q <= WIDTH'(TH_LO);
    end else if (state_q == ST_LOW) begin
      th_hi_q <= th_hi;
      th_lo_q <= th_lo;
    end
  end

  assign th_hi_cur = th_hi_q;
  assign th_lo_cur = th_lo_q;
`else
  assign th_hi_cur = WIDTH'(TH_HI);
  assign th_lo_cur = WIDTH'(TH_LO);
`endif

  assign valid       = bus.in_valid;
  assign sample      = bus.in_data;
  assign hi_ok       = (sample >= th_hi_cur);
  assign lo_ok       = (sample <= th_lo_cur);
  assign tracked_max = (sample > tracker_q) ? sample : tracker_q;

  // Hold counter control: count qualifying samples toward HOLD, restart
  // whenever the run breaks or a level change completes.
  always_comb begin
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    if (valid) begin
      if ((state_q == ST_LOW) || (state_q == ST_ARM_HI)) begin
        if (hi_ok && !cnt_tc) cnt_en = 1'b1;
        else                  cnt_clear = 1'b1;
      end else begin
        if (lo_ok && !cnt_tc) cnt_en = 1'b1;
        else                  cnt_clear = 1'b1;
      end
    end
  end

  threshold_detector_hold_counter #(
    .HOLD (HOLD)
  ) u_hold (
    .CLK      (CLK),
    .RST      (RST),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .tc_o     (cnt_tc)
  );

  // Level FSM with peak tracker, event counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_LOW;
      level_q      <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_q       <= '0;
      tracker_q    <= '0;
      count_q      <= '0;
    end else begin
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      peak_valid_q <= 1'b0;
      if (valid) begin
        case (state_q)
          ST_LOW, ST_ARM_HI: begin
            if (hi_ok) begin
              // A fresh run starts the tracker from this sample.
              tracker_q <= (state_q == ST_LOW) ? sample : tracked_max;
              if (cnt_tc) begin
                state_q <= ST_HIGH;
                level_q <= 1'b1;
                rise_q  <= 1'b1;
                count_q <= count_q + CNT_W'(1);
              end else begin
                state_q <= ST_ARM_HI;
              end
            end else begin
              state_q   <= ST_LOW;
              tracker_q <= '0;
            end
          end
          ST_HIGH, ST_ARM_LO: begin
            tracker_q <= tracked_max;
            if (lo_ok) begin
              if (cnt_tc) begin
                state_q      <= ST_LOW;
                level_q      <= 1'b0;
                fall_q       <= 1'b1;
                peak_valid_q <= 1'b1;
                peak_q       <= tracked_max;
                tracker_q    <= '0;
              end else begin
                state_q <= ST_ARM_LO;
              end
            end else begin
              state_q <= ST_HIGH;
            end
          end
          default: state_q <= ST_LOW;
        endcase
      end
    end
  end

  assign bus.level       = level_q;
  assign bus.rise_pulse  = rise_q;
  assign bus.fall_pulse  = fall_q;
  assign bus.peak        = peak_q;
  assign bus.peak_valid  = peak_valid_q;
  assign bus.event_count = count_q;
endmodule
